spike_recall_decoder: RTL

- Sits directly downstream of the Hopfield network and consumes its N-bit neuron spike vector.
- On a start request, it waits out a settle interval and then counts rising spike edges per neuron over a fixed window.
- Thresholds the counts into a recalled binary pattern, reports the most active neuron, and holds the result under a valid/ready handshake.
- Gives the top level and the pattern sequencer a clean "recalled pattern" result instead of raw spike trains.

---
 rtl/hopfield_pkg.sv | 24 ++
 rtl/spike_edge_counter.sv | 41 ++++
 rtl/spike_recall_decoder.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/hopfield_pkg.sv
// Shared types and defaults for the Hopfield spike recall decoder.
// The optional Hamming-distance output is selected with RECALL_HAMMING_EN.
package hopfield_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETTLE,
    S_COUNT,
    S_EVAL,
    S_HOLD
  } state_t;

  localparam int N_DEF      = 7;
  localparam int CNT_W_DEF  = 8;
  localparam int THRESH_DEF = 4;

  // Width of a neuron index; a single neuron still gets a 1-bit index.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int WINNER_W_DEF = idx_width(N_DEF);

endpackage

// File: rtl/spike_edge_counter.sv
// Per-neuron rising-edge detector feeding a saturating spike counter.
module spike_edge_counter
  import hopfield_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_spike,
  input  logic             i_clear,
  input  logic             i_enable,
  output logic [CNT_W-1:0] o_count
);

  logic             r_spk_prev;
  logic [CNT_W-1:0] r_count;
  logic             w_rise;

  assign w_rise = i_spike & ~r_spk_prev;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_spk_prev <= 1'b0;
      r_count    <= '0;
    end else begin
      // The edge history tracks the input in every state, so a level held
      // across the start of counting never looks like a fresh edge.
      r_spk_prev <= i_spike;
      if (i_clear) begin
        r_count <= '0;
      end else if (i_enable && w_rise && (r_count != '1)) begin
        r_count <= r_count + 1'b1;
      end
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/spike_recall_decoder.sv
// Measures per-neuron spike activity over a window and reports the recalled
// pattern plus the most active neuron. RECALL_HAMMING_EN adds a target compare.
module spike_recall_decoder
  import hopfield_pkg::*;
#(
  parameter  int N      = N_DEF,
  parameter  int CNT_W  = CNT_W_DEF,
  parameter  int WINDOW = 64,
  parameter  int SETTLE = 16,
  parameter  int THRESH = THRESH_DEF,
  localparam int WIN_W  = idx_width(N)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     spikes,
  input  logic             start,
  input  logic             out_ready,
  output logic             busy,
  output logic             out_valid,
  output logic [N-1:0]     pattern_out,
  output logic [WIN_W-1:0] winner,
  output logic [CNT_W-1:0] winner_cnt
`ifdef RECALL_HAMMING_EN
  ,
  input  logic [N-1:0]            target_pattern,
  output logic [$clog2(N+1)-1:0]  hamming_dist
`endif
);

  localparam int SET_W = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam int WC_W  = $clog2(WINDOW + 1);

  state_t           r_state;
  state_t           w_next;
  logic [SET_W-1:0] r_settle_cnt;
  logic [WC_W-1:0]  r_win_cnt;
  logic             w_clear;
  logic             w_count_en;
  logic             w_settle_last;
  logic             w_window_last;

  logic [CNT_W-1:0] w_counts [N];
  logic [N-1:0]     w_pattern;
  logic [WIN_W-1:0] w_winner;
  logic [CNT_W-1:0] w_winner_cnt;

  for (genvar g = 0; g < N; g++) begin : g_neuron
    spike_edge_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk      (clk),
      .reset    (reset),
      .i_spike  (spikes[g]),
      .i_clear  (w_clear),
      .i_enable (w_count_en),
      .o_count  (w_counts[g])
    );
  end

  assign w_settle_last = (r_settle_cnt == SET_W'(SETTLE - 1));
  assign w_window_last = (r_win_cnt == WC_W'(WINDOW - 1));

  // NOTE: every signal written here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    w_next     = r_state;
    w_clear    = 1'b0;
    w_count_en = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_clear = 1'b1;
          w_next  = (SETTLE == 0) ? S_COUNT : S_SETTLE;
        end
      end
      S_SETTLE: if (w_settle_last) w_next = S_COUNT;
      S_COUNT: begin
        w_count_en = 1'b1;
        if (w_window_last) w_next = S_EVAL;
      end
      S_EVAL:  w_next = S_HOLD;
      S_HOLD:  if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_settle_cnt <= '0;
      r_win_cnt    <= '0;
    end else begin
      r_state      <= w_next;
      r_settle_cnt <= (r_state == S_SETTLE) ? r_settle_cnt + 1'b1 : '0;
      r_win_cnt    <= (r_state == S_COUNT) ? r_win_cnt + 1'b1 : '0;
    end
  end

  // Strict greater-than keeps the lowest index on ties; all-zero counts
  // leave winner and winner_cnt at 0.
  always_comb begin
    w_pattern    = '0;
    w_winner     = '0;
    w_winner_cnt = '0;
    for (int i = 0; i < N; i++) begin
      w_pattern[i] = (w_counts[i] >= CNT_W'(THRESH));
      if (w_counts[i] > w_winner_cnt) begin
        w_winner     = WIN_W'(i);
        w_winner_cnt = w_counts[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pattern_out <= '0;
      winner      <= '0;
      winner_cnt  <= '0;
    end else if (r_state == S_EVAL) begin
      pattern_out <= w_pattern;
      winner      <= w_winner;
      winner_cnt  <= w_winner_cnt;
    end
  end

`ifdef RECALL_HAMMING_EN
  logic [N-1:0]           r_target;
  logic [$clog2(N+1)-1:0] w_hamming;

  always_comb begin
    w_hamming = '0;
    for (int i = 0; i < N; i++) begin
      w_hamming = w_hamming + ($clog2(N+1))'(w_pattern[i] ^ r_target[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_target     <= '0;
      hamming_dist <= '0;
    end else begin
      if (r_state == S_IDLE && start) r_target <= target_pattern;
      if (r_state == S_EVAL) hamming_dist <= w_hamming;
    end
  end
`endif

  assign busy      = (r_state != S_IDLE);
  assign out_valid = (r_state == S_HOLD);

endmodule
